ofm_drain: RTL and testbench

//  Output-side drain for the 3x3 conv systolic array. Round-robin pops the three

---
 rtl/ofm_drain.sv | 157 +++++++++++++++
 tb/tb_ofm_drain.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_drain.sv
// Output drain for the 3x3 conv array: round-robin pops three column buffers and
// serialises their partial sums onto one valid/ready stream with column tag, ReLU and framing.
module ofm_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 9,
  parameter int RELU_EN    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    obf0_empty,
  input  logic                    obf1_empty,
  input  logic                    obf2_empty,
  input  logic                    obf0_err,
  input  logic                    obf1_err,
  input  logic                    obf2_err,
  input  logic [2*DATA_WIDTH-1:0] obf0_out,
  input  logic [2*DATA_WIDTH-1:0] obf1_out,
  input  logic [2*DATA_WIDTH-1:0] obf2_out,
  output logic                    obf0_rd_en,
  output logic                    obf1_rd_en,
  output logic                    obf2_rd_en,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*DATA_WIDTH-1:0] m_data,
  output logic [1:0]              m_ch,
  output logic                    m_last,
  output logic                    busy,
  output logic                    err_sticky
);

  localparam int WW = 2 * DATA_WIDTH;
  localparam logic [15:0] LAST_BEAT = 16'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, SEND} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      ptr_reg, ptr_next;
  logic [1:0]      sel_reg, sel_next;
  logic [15:0]     beat_cnt_reg, beat_cnt_next;
  logic [WW-1:0]   data_reg;
  logic [1:0]      ch_reg;
  logic            last_reg;
  logic            err_reg, err_next;

  logic [2:0]      empty_vec;
  logic [2:0]      err_vec;
  logic [2:0]      rd_en_vec;
  logic [WW-1:0]   out_vec [3];
  logic [WW-1:0]   word_relu;
  logic [1:0]      pick;
  logic [1:0]      cand;
  logic            found;

  assign empty_vec  = {obf2_empty, obf1_empty, obf0_empty};
  assign err_vec    = {obf2_err, obf1_err, obf0_err};
  assign out_vec[0] = obf0_out;
  assign out_vec[1] = obf1_out;
  assign out_vec[2] = obf2_out;

  function automatic logic [1:0] next3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // One-hot pop strobe, only ever for the selected column while in ISSUE.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rd
      assign rd_en_vec[gi] = (state_reg == ISSUE) && (sel_reg == 2'(gi));
    end
  endgenerate

  assign obf0_rd_en = rd_en_vec[0];
  assign obf1_rd_en = rd_en_vec[1];
  assign obf2_rd_en = rd_en_vec[2];

  // Scan ptr, ptr+1, ptr+2 (mod 3); the first non-empty column wins.
  always_comb begin
    found = 1'b0;
    pick  = ptr_reg;
    cand  = ptr_reg;
    for (int i = 0; i < 3; i++) begin
      if (!found && !empty_vec[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = next3(cand);
    end
  end

  assign word_relu = ((RELU_EN != 0) && out_vec[sel_reg][WW-1]) ? '0 : out_vec[sel_reg];

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    sel_next      = sel_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          sel_next   = pick;
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = SEND;
      SEND: begin
        if (m_ready) begin
          ptr_next      = next3(sel_reg);
          beat_cnt_next = last_reg ? 16'd0 : beat_cnt_reg + 16'd1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (clr) begin
      state_next    = IDLE;
      ptr_next      = 2'd0;
      beat_cnt_next = 16'd0;
    end
  end

  // An error seen in the same cycle as clr still sets the flag.
  assign err_next = (|err_vec) | (err_reg & ~clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= 2'd0;
      sel_reg      <= 2'd0;
      beat_cnt_reg <= 16'd0;
      data_reg     <= '0;
      ch_reg       <= 2'd0;
      last_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      sel_reg      <= sel_next;
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_next;
      if (state_reg == CAPTURE && !clr) begin
        data_reg <= word_relu;
        ch_reg   <= sel_reg;
        last_reg <= (beat_cnt_reg == LAST_BEAT);
      end
    end
  end

  assign m_valid    = (state_reg == SEND);
  assign m_data     = data_reg;
  assign m_ch       = ch_reg;
  assign m_last     = last_reg & m_valid;
  assign busy       = (state_reg != IDLE);
  assign err_sticky = err_reg;

endmodule

// File: tb/tb_ofm_drain.sv
// Scoreboard bench for ofm_drain: behavioural column buffers feed the DUT, expected
// beats are queued at stimulus time and compared on each stream handshake.
module tb_ofm_drain;

  localparam int DW = 8;
  localparam int FL = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        obf0_empty, obf1_empty, obf2_empty;
  logic        obf0_err = 1'b0, obf1_err = 1'b0, obf2_err = 1'b0;
  logic [15:0] obf0_out = '0, obf1_out = '0, obf2_out = '0;
  logic        obf0_rd_en, obf1_rd_en, obf2_rd_en;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;
  logic [1:0]  m_ch;
  logic        m_last;
  logic        busy;
  logic        err_sticky;

  ofm_drain #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .RELU_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .obf0_empty(obf0_empty), .obf1_empty(obf1_empty), .obf2_empty(obf2_empty),
    .obf0_err(obf0_err), .obf1_err(obf1_err), .obf2_err(obf2_err),
    .obf0_out(obf0_out), .obf1_out(obf1_out), .obf2_out(obf2_out),
    .obf0_rd_en(obf0_rd_en), .obf1_rd_en(obf1_rd_en), .obf2_rd_en(obf2_rd_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch),
    .m_last(m_last), .busy(busy), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          exp_beat = 0;
  int          npass = 0;
  int          ntotal = 0;
  int          cyc = 0;
  int          rd_cnt [3] = '{0, 0, 0};
  logic        chk_interval = 1'b0;

  // Column buffer models: registered read, data valid the cycle after rd_en.
  logic [15:0] mem [3][64];
  int          wr_ptr [3] = '{0, 0, 0};
  int          rd_ptr [3] = '{0, 0, 0};

  assign obf0_empty = (wr_ptr[0] == rd_ptr[0]);
  assign obf1_empty = (wr_ptr[1] == rd_ptr[1]);
  assign obf2_empty = (wr_ptr[2] == rd_ptr[2]);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (obf0_rd_en && !obf0_empty) begin obf0_out <= mem[0][rd_ptr[0]]; rd_ptr[0] <= rd_ptr[0] + 1; end
    if (obf1_rd_en && !obf1_empty) begin obf1_out <= mem[1][rd_ptr[1]]; rd_ptr[1] <= rd_ptr[1] + 1; end
    if (obf2_rd_en && !obf2_empty) begin obf2_out <= mem[2][rd_ptr[2]]; rd_ptr[2] <= rd_ptr[2] + 1; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    ntotal++;
    if (got === want) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic [15:0] relu_model(input logic [15:0] w);
    return w[15] ? 16'h0000 : w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int c, input logic [15:0] w);
    mem[c][wr_ptr[c]] = w;
    wr_ptr[c] = wr_ptr[c] + 1;
  endtask

  task automatic expect_word(input int c, input logic [15:0] w);
    exp_t e;
    e.ch   = 2'(c);
    e.data = relu_model(w);
    e.last = (exp_beat == FL - 1);
    exp_q.push_back(e);
    exp_beat = (exp_beat == FL - 1) ? 0 : exp_beat + 1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || busy); i++) tick();
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !m_valid; i++) tick();
    check("valid_wait", m_valid, 1);
  endtask

  // Stream monitor: one line per accepted beat, compared against the scoreboard head.
  logic hs_seen = 1'b0;
  int   last_hs = 0;
  always @(negedge clk) begin
    logic [2:0] rd;
    rd = {obf2_rd_en, obf1_rd_en, obf0_rd_en};
    if (|rd) check("one_rd_en", $countones(rd), 1);
    for (int c = 0; c < 3; c++) if (rd[c]) rd_cnt[c]++;
    if (rst_n && m_valid && m_ready) begin
      $display("beat ch=%0d data=%04h last=%0b", m_ch, m_data, m_last);
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("beat_ch", m_ch, e.ch);
        check("beat_data", m_data, e.data);
        check("beat_last", m_last, e.last);
      end
      if (chk_interval) begin
        if (hs_seen) check("interval", cyc - last_hs, 4);
        hs_seen = 1'b1;
        last_hs = cyc;
      end else begin
        hs_seen = 1'b0;
      end
    end
  end

  initial begin
    logic [15:0] d_hold;
    logic [1:0]  c_hold;
    int          rd_before;

    repeat (2) tick();
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_sticky, 0);
    check("rst_rd_en", {obf2_rd_en, obf1_rd_en, obf0_rd_en}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Warm-up beat on column 0 moves ptr to 1 before the reset test.
    load(0, 16'h0011);
    expect_word(0, 16'h0011);
    wait_drain(50);

    // Reset while a word sits unaccepted in SEND.
    m_ready = 1'b0;
    load(2, 16'h0222);
    wait_valid(20);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_data", m_data, 0);
    check("arst_ch", m_ch, 0);
    check("arst_last", m_last, 0);
    check("arst_busy", busy, 0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    exp_beat = 0;
    m_ready = 1'b1;
    tick();

    // All three columns loaded: ptr restarts at 0, one word every 4 cycles.
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 3; c++) load(c, 16'(16'h0100 * (c + 1) + k));
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 3; c++) expect_word(c, 16'(16'h0100 * (c + 1) + k));
    chk_interval = 1'b1;
    wait_drain(100);
    chk_interval = 1'b0;
    tick();

    // Single column latency: m_valid on the third edge after empty falls.
    rd_before = rd_cnt[1];
    load(1, 16'h0123);
    expect_word(1, 16'h0123);
    tick();
    check("lat_edge1", m_valid, 0);
    tick();
    check("lat_edge2", m_valid, 0);
    tick();
    check("lat_edge3", m_valid, 1);
    check("lat_data", m_data, 16'h0123);
    check("lat_ch", m_ch, 1);
    wait_drain(20);
    check("lat_pulses", rd_cnt[1] - rd_before, 1);

    // Backpressure: held word stays stable, no further pops.
    m_ready = 1'b0;
    load(0, 16'h0055);
    expect_word(0, 16'h0055);
    wait_valid(20);
    d_hold = m_data;
    c_hold = m_ch;
    rd_before = rd_cnt[0] + rd_cnt[1] + rd_cnt[2];
    load(1, 16'h0066);
    repeat (10) tick();
    check("bp_valid", m_valid, 1);
    check("bp_data", m_data, d_hold);
    check("bp_ch", m_ch, c_hold);
    check("bp_no_pop", rd_cnt[0] + rd_cnt[1] + rd_cnt[2], rd_before);
    expect_word(1, 16'h0066);
    m_ready = 1'b1;
    wait_drain(50);

    // ReLU: negative word zeroed, positive passes (ptr now at 2 after column 1).
    load(2, 16'hFF9C);
    load(0, 16'h0064);
    expect_word(2, 16'hFF9C);
    expect_word(0, 16'h0064);
    wait_drain(50);

    // Clear, then 18 beats: m_last only on beats 8 and 17.
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_beat = 0;
    for (int k = 0; k < 6; k++)
      for (int c = 0; c < 3; c++) load(c, 16'($urandom_range(0, 16'h7FFF)));
    for (int k = 0; k < 6; k++)
      for (int c = 0; c < 3; c++) expect_word(c, mem[c][wr_ptr[c] - 6 + k]);
    wait_drain(300);

    // Sticky error flag.
    tick();
    check("err_idle", err_sticky, 0);
    obf2_err = 1'b1;
    tick();
    obf2_err = 1'b0;
    check("err_set", err_sticky, 1);
    repeat (3) tick();
    check("err_hold", err_sticky, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("err_clr", err_sticky, 0);
    obf0_err = 1'b1;
    clr = 1'b1;
    tick();
    obf0_err = 1'b0;
    clr = 1'b0;
    check("err_set_wins", err_sticky, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("err_clr2", err_sticky, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
